// File: rtl/lcd_txn_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_txn_scheduler
//
// Purpose:
//   Arbitrates between two LCD clients (a command client and a character
//   client). It hands one 10-bit word {RS,RW,D[7:0]} at a time to the
//   nibble-write instruction engine. After the engine finishes, it waits
//   long enough for the LCD controller to complete the instruction.
//   Clear/home instructions get the long wait; everything else gets the
//   short wait.
//
// Handshake (both clients):
//   A client raises *_req with a stable *_data and holds both until it sees
//   a one-cycle *_ack. The ack means the word has been captured, so the
//   client may drop or change its request from the cycle after the ack.
//   Requests are only sampled in IDLE. A request raised during RUN or HOLD
//   simply waits. The engine is driven by eng_en (level, high for the whole
//   RUN state) and answers with a single-cycle eng_done. eng_done is ignored
//   in every other state.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   cmd_req    in   command client request
//   cmd_data   in   command word {RS,RW,D[7:0]}
//   cmd_ack    out  one-cycle pulse, command word captured
//   chr_req    in   character client request
//   chr_data   in   character word {RS,RW,D[7:0]}
//   chr_ack    out  one-cycle pulse, character word captured
//   eng_en     out  enable to the nibble-write engine (high in RUN)
//   eng_data   out  word presented to the engine (0 outside RUN)
//   eng_done   in   one-cycle completion pulse from the engine
//   busy       out  high whenever the state is not IDLE
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 HOLD)
//
// Configuration:
//   LCD_SCHED_RR_EN  undefined: fixed priority, cmd wins a tie.
//                    defined:   round-robin on a last-grant pointer that
//                               resets to "chr", so cmd wins the first tie.
// ---------------------------------------------------------------------------
module lcd_txn_scheduler #(
  parameter int unsigned T_SHORT = 1999,
  parameter int unsigned T_LONG  = 81999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic [9:0] cmd_data,
  output logic       cmd_ack,
  input  logic       chr_req,
  input  logic [9:0] chr_data,
  output logic       chr_ack,
  output logic       eng_en,
  output logic [9:0] eng_data,
  input  logic       eng_done,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [19:0] LIM_SHORT = 20'(T_SHORT);
  localparam logic [19:0] LIM_LONG  = 20'(T_LONG);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [9:0]  word_q, word_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        chr_ack_q, chr_ack_d;
  logic        eng_en_q, eng_en_d;
  logic [9:0]  eng_data_q, eng_data_d;
  logic        busy_q, busy_d;

  logic        pick_cmd;
  logic        pick_chr;
  logic        is_clr_home;
  logic [19:0] limit;

`ifdef LCD_SCHED_RR_EN
  // Last-grant pointer: 1 = chr was granted last, 0 = cmd was granted last.
  logic last_chr_q, last_chr_d;
`endif

  // Clear (0x01) and home (0x02/0x03) are the only instructions that need
  // the long wait: RS=0, RW=0, D[7:2]=0 and D[1:0] non-zero.
  assign is_clr_home = (word_q[9:2] == 8'd0) && (word_q[1:0] != 2'd0);
  assign limit       = is_clr_home ? LIM_LONG : LIM_SHORT;

  // Winner selection. A lone request always wins. A tie goes to cmd in
  // fixed-priority mode, or to the client not granted last in round-robin.
`ifdef LCD_SCHED_RR_EN
  assign pick_cmd = cmd_req && (!chr_req || last_chr_q);
`else
  assign pick_cmd = cmd_req;
`endif
  assign pick_chr = chr_req && !pick_cmd;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    cmd_ack_d  = 1'b0;
    chr_ack_d  = 1'b0;
`ifdef LCD_SCHED_RR_EN
    last_chr_d = last_chr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pick_cmd) begin
          word_d     = cmd_data;
          cmd_ack_d  = 1'b1;
          state_d    = ST_RUN;
`ifdef LCD_SCHED_RR_EN
          last_chr_d = 1'b0;
`endif
        end else if (pick_chr) begin
          word_d     = chr_data;
          chr_ack_d  = 1'b1;
          state_d    = ST_RUN;
`ifdef LCD_SCHED_RR_EN
          last_chr_d = 1'b1;
`endif
        end
      end

      ST_RUN: begin
        if (eng_done) begin
          state_d = ST_HOLD;
          cnt_d   = 20'd0;
        end
      end

      ST_HOLD: begin
        // The counter shows 0 in the first HOLD cycle, so HOLD lasts
        // limit+1 cycles.
        if (cnt_q == limit) begin
          state_d = ST_IDLE;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 20'd0;
      end
    endcase

    // The outputs are derived from the next state, so the registered copies
    // line up with state_q in the following cycle.
    eng_en_d   = (state_d == ST_RUN);
    eng_data_d = (state_d == ST_RUN) ? word_d : 10'd0;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 20'd0;
      word_q     <= 10'd0;
      cmd_ack_q  <= 1'b0;
      chr_ack_q  <= 1'b0;
      eng_en_q   <= 1'b0;
      eng_data_q <= 10'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      cmd_ack_q  <= cmd_ack_d;
      chr_ack_q  <= chr_ack_d;
      eng_en_q   <= eng_en_d;
      eng_data_q <= eng_data_d;
      busy_q     <= busy_d;
    end
  end

`ifdef LCD_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_chr_q <= 1'b1;
    end else begin
      last_chr_q <= last_chr_d;
    end
  end
`endif

  assign cmd_ack   = cmd_ack_q;
  assign chr_ack   = chr_ack_q;
  assign eng_en    = eng_en_q;
  assign eng_data  = eng_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_txn_scheduler
//
// Directed bench for lcd_txn_scheduler with T_SHORT=3 and T_LONG=9.
//
// Timing conventions:
//   - Inputs are driven, and outputs are sampled, on the falling edge.
//   - Cycle N is the first RUN cycle, the one in which the ack is visible.
//   - An input set at the falling edge of cycle k is sampled at the rising
//     edge that ends cycle k.
//
// Checking is split in two:
//   - The stimulus pushes the expected {src, word} of every transaction into
//     exp_q. A monitor pops and compares whenever an ack appears.
//   - Cycle-exact timing (eng_en and busy edges) is checked from the
//     stimulus side.
// ---------------------------------------------------------------------------
module tb_lcd_txn_scheduler;

  localparam int T_SHORT = 3;
  localparam int T_LONG  = 9;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_req, chr_req, eng_done;
  logic [9:0] cmd_data, chr_data;
  logic       cmd_ack, chr_ack, eng_en, busy;
  logic [9:0] eng_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  lcd_txn_scheduler #(.T_SHORT(T_SHORT), .T_LONG(T_LONG)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_req  (cmd_req),
    .cmd_data (cmd_data),
    .cmd_ack  (cmd_ack),
    .chr_req  (chr_req),
    .chr_data (chr_data),
    .chr_ack  (chr_ack),
    .eng_en   (eng_en),
    .eng_data (eng_data),
    .eng_done (eng_done),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry = {src, word}; src 0 = cmd, 1 = chr.
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every ack must match the head of the expected queue.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (cmd_ack || chr_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: got cmd_ack=%0b chr_ack=%0b word=0x%0h, expected no ack (t=%0t)",
                   cmd_ack, chr_ack, eng_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_src_word", {21'd0, chr_ack, eng_data}, {21'd0, e});
          check("ack_pair", {30'd0, cmd_ack, chr_ack}, e[10] ? 32'd1 : 32'd2);
          check("ack_eng_en", {31'd0, eng_en}, 32'd1);
          check("ack_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  // Watchdog: stops the run even if the bench itself gets stuck.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // Waits for an ack and checks how many cycles it took.
  task automatic wait_ack(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(cmd_ack || chr_ack) && lat < 20);
    check("ack_latency", lat, exp_lat);
  endtask

  // Called at the falling edge of cycle N.
  //   - eng_done is pulsed at N+done_off.
  //   - A stray eng_done is pulsed two cycles later, inside HOLD.
  //   - busy must fall exactly at N+idle_off.
  task automatic do_txn(input int done_off, input int idle_off);
    for (int k = 1; k <= idle_off; k++) begin
      @(negedge clk);
      eng_done = (k == done_off) || (k == done_off + 2);
      check("no_ack_mid_txn", {30'd0, cmd_ack, chr_ack}, 32'd0);
      if (k == done_off) check("run_eng_en", {31'd0, eng_en}, 32'd1);
      if (k == done_off + 1) begin
        check("hold_eng_en", {31'd0, eng_en}, 32'd0);
        check("hold_eng_data", {22'd0, eng_data}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
      end
      if (k == idle_off - 1) check("busy_last_hold", {31'd0, busy}, 32'd1);
      if (k == idle_off) begin
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("state_idle", {30'd0, dbg_state}, 32'd0);
      end
    end
    eng_done = 1'b0;
  endtask

  // Single-client transaction table: {src, word, idle_off}.
  // Clear/home words (0x001, 0x002) take the long wait and go idle at N+16.
  // All other words take the short wait and go idle at N+10.
  typedef struct packed {
    logic       src;
    logic [9:0] word;
    logic [7:0] idle_off;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{src: 1'b0, word: 10'h028, idle_off: 8'd10};
    vecs[1] = '{src: 1'b0, word: 10'h001, idle_off: 8'd16};
    vecs[2] = '{src: 1'b0, word: 10'h00C, idle_off: 8'd10};
    vecs[3] = '{src: 1'b1, word: 10'h002, idle_off: 8'd16};
    vecs[4] = '{src: 1'b0, word: 10'h101, idle_off: 8'd10};
    vecs[5] = '{src: 1'b1, word: 10'h201, idle_off: 8'd10};
    vecs[6] = '{src: 1'b1, word: 10'h000, idle_off: 8'd10};
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] order[4];

    // Reset held low for 2 cycles with both requests high.
    reset    = 1'b0;
    cmd_req  = 1'b1;
    chr_req  = 1'b1;
    cmd_data = 10'h3FF;
    chr_data = 10'h3FF;
    eng_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_eng_en", {31'd0, eng_en}, 32'd0);
    check("rst_eng_data", {22'd0, eng_data}, 32'd0);
    check("rst_acks", {30'd0, cmd_ack, chr_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset   = 1'b1;
    cmd_req = 1'b0;
    chr_req = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single-client transactions, short and long waits. The table ends on a
    // chr grant, so a round-robin pointer points at chr for the tie test.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].src) begin
        chr_req  = 1'b1;
        chr_data = vecs[i].word;
      end else begin
        cmd_req  = 1'b1;
        cmd_data = vecs[i].word;
      end
      exp_q.push_back({vecs[i].src, vecs[i].word});
      wait_ack(1);
      cmd_req = 1'b0;
      chr_req = 1'b0;
      do_txn(5, int'(vecs[i].idle_off));
    end

    // Simultaneous requests: cmd first, chr only after cmd's HOLD ends.
    cmd_req  = 1'b1;
    cmd_data = 10'h028;
    chr_req  = 1'b1;
    chr_data = 10'h241;
    exp_q.push_back({1'b0, 10'h028});
    exp_q.push_back({1'b1, 10'h241});
    wait_ack(1);
    cmd_req = 1'b0;
    do_txn(5, 10);
    wait_ack(1);
    chr_req = 1'b0;
    do_txn(5, 10);

    // Both requests held over 4 transactions.
`ifdef LCD_SCHED_RR_EN
    order[0] = {1'b0, 10'h028};
    order[1] = {1'b1, 10'h241};
    order[2] = {1'b0, 10'h028};
    order[3] = {1'b1, 10'h241};
`else
    order[0] = {1'b0, 10'h028};
    order[1] = {1'b0, 10'h028};
    order[2] = {1'b0, 10'h028};
    order[3] = {1'b0, 10'h028};
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(order[i]);
    cmd_req = 1'b1;
    chr_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(1);
      if (t == 3) begin
        cmd_req = 1'b0;
        chr_req = 1'b0;
      end
      do_txn(1, 6);
    end

    // Reset during RUN, with a stray eng_done while the DUT is idle. The
    // cmd request is held throughout and must be re-acked.
    cmd_req  = 1'b1;
    cmd_data = 10'h028;
    exp_q.push_back({1'b0, 10'h028});
    wait_ack(1);                        // cycle N
    @(negedge clk);                     // N+1
    @(negedge clk);                     // N+2
    reset = 1'b0;
    exp_q.push_back({1'b0, 10'h028});   // fresh transaction after reset
    @(negedge clk);                     // N+3
    check("rst_run_eng_en", {31'd0, eng_en}, 32'd0);
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_data", {22'd0, eng_data}, 32'd0);
    @(negedge clk);                     // N+4
    check("rst_run_acks", {30'd0, cmd_ack, chr_ack}, 32'd0);
    reset    = 1'b1;
    eng_done = 1'b1;                    // stray pulse, sampled in IDLE
    @(negedge clk);                     // N+5: re-acked
    eng_done = 1'b0;
    check("reack_cmd", {31'd0, cmd_ack}, 32'd1);
    cmd_req = 1'b0;
    do_txn(5, 10);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
